// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrated mux.
// Optional forced-select ports are enabled with RR_ARB_MUX_FORCE_SEL_EN.
package rr_arb_mux_pkg;

  localparam int DEF_N_SLAVES   = 4;
  localparam int DEF_DATA_WIDTH = 4;

  // Advance an index by one, wrapping at n-1 (not at a power of two).
  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// The search wraps at N-1 back to 0; ptr is owned by the parent.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  // Scan N positions starting at ptr and latch onto the first active request.
  always_comb begin : search
    int  idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Registered round-robin N-to-1 mux with valid/ready on every channel.
// Define RR_ARB_MUX_FORCE_SEL_EN to add force_en/force_sel overriding the arbiter.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter  int N_SLAVES   = DEF_N_SLAVES,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int SEL_W      = $clog2(N_SLAVES)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_SLAVES-1:0]            in_valid,
  output logic [N_SLAVES-1:0]            in_ready,
  input  logic [DATA_WIDTH*N_SLAVES-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
`ifdef RR_ARB_MUX_FORCE_SEL_EN
  input  logic                           force_en,
  input  logic [SEL_W-1:0]               force_sel,
`endif
  output logic [SEL_W-1:0]               out_sel
);

  logic [SEL_W-1:0]      ptr_reg;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [SEL_W-1:0]      out_sel_reg;

  logic [N_SLAVES-1:0]   arb_gnt;
  logic [SEL_W-1:0]      arb_idx;
  logic [N_SLAVES-1:0]   grant_vec;
  logic [SEL_W-1:0]      grant_idx;
  logic                  grant_ok;
  logic                  advance_ptr;
  logic                  can_load;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] data_arr [N_SLAVES];
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arbiter #(.N(N_SLAVES)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_reg),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Unflatten the channel data bus into one beat per channel.
  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_unpack
    assign data_arr[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef RR_ARB_MUX_FORCE_SEL_EN
  // Forced select bypasses the arbiter; an out-of-range index grants nothing.
  always_comb begin
    grant_vec   = arb_gnt;
    grant_idx   = arb_idx;
    grant_ok    = |in_valid;
    advance_ptr = 1'b1;
    if (force_en) begin
      grant_vec   = '0;
      grant_idx   = force_sel;
      grant_ok    = 1'b0;
      advance_ptr = 1'b0;
      for (int i = 0; i < N_SLAVES; i++) begin
        if (force_sel == SEL_W'(i) && in_valid[i]) begin
          grant_vec[i] = 1'b1;
          grant_ok     = 1'b1;
        end
      end
    end
  end
`else
  assign grant_vec   = arb_gnt;
  assign grant_idx   = arb_idx;
  assign grant_ok    = |in_valid;
  assign advance_ptr = 1'b1;
`endif

  assign can_load = !out_valid_reg || out_ready;
  assign xfer     = rst_n && can_load && grant_ok;
  assign in_ready = xfer ? grant_vec : '0;

  // Pick the granted channel's beat; compare-based so odd N never indexes past the array.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (grant_idx == SEL_W'(i)) sel_data = data_arr[i];
    end
  end

  // Output register and round-robin pointer: load on transfer, drain on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      ptr_reg       <= '0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= sel_data;
      out_sel_reg   <= grant_idx;
      if (advance_ptr) ptr_reg <= SEL_W'(next_idx(int'(grant_idx), N_SLAVES));
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Registered, round-robin arbitrated N-to-1 multiplexer.
- Successor to the combinational sel-driven mux: N_SLAVES sources each present a DATA_WIDTH beat with valid/ready, and the block grants one source per cycle.
- It forwards the granted beat through a single output register and tags it with the source index.
- Sits between multiple producers and a single shared consumer.

Parameters:
- N_SLAVES, 4, number of input channels; legal range 2 and up, need not be a power of two.
- DATA_WIDTH, 4, width of each channel's data beat.
- SEL_W, $clog2(N_SLAVES), derived localparam; width of the source index.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  N_SLAVES  per-channel beat valid; bit i belongs to channel i.
- in_ready  output  N_SLAVES  per-channel accept.
- in_data  input  DATA_WIDTH*N_SLAVES  flattened data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accept.
- out_data  output  DATA_WIDTH  registered granted beat.
- out_sel  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (rst_n low at a rising edge): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
- While in reset, in_ready=0. Any held or in-flight beat is discarded.
- Grant (combinational): g is the first index i with in_valid[i]=1, searching ptr, ptr+1, ... N_SLAVES-1, then 0 ... ptr-1. The search wraps at N_SLAVES-1 to 0; it does not wrap at 2^SEL_W.
- can_load = !out_valid || out_ready.
- in_ready[i] = can_load && any(in_valid) && (i==g). At most one in_ready bit is high in any cycle.
- Transfer on channel i occurs when in_valid[i] && in_ready[i]. On a transfer, at the next edge:
  - out_data <= slice g
  - out_sel <= g
  - out_valid <= 1
  - ptr <= (g==N_SLAVES-1) ? 0 : g+1
- No transfer and out_ready=1: out_valid <= 0. out_data and out_sel hold their values (don't-care).
- No transfer and out_ready=0: all state holds.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle when out_ready is held high. Simultaneous output drain and new load in the same cycle is required (no bubble).
- Stability: while out_valid && !out_ready, out_data and out_sel hold constant.
- Upstream rule: once in_valid[i] is asserted, it and the channel's data hold until accepted. The block is not required to tolerate violation.
- Fairness: under continuous requests from all channels, grants rotate 0,1,...,N-1,0. Each requester is served within N_SLAVES accepted beats.
- ptr advances only on a transfer. It does not advance while stalled.
- No valid inputs: in_ready=0, ptr holds.

Optional Feature:
- Macro: RR_ARB_MUX_FORCE_SEL_EN.
- Defined: adds two ports, force_en (input, 1) and force_sel (input, SEL_W).
  - When force_en=1, g=force_sel, bypassing round-robin.
  - Transfer occurs only if in_valid[force_sel]=1; ptr is not updated on forced transfers.
  - force_sel >= N_SLAVES: no channel is granted and in_ready=0.
- Not defined: the ports do not exist and the behaviour is pure round-robin as above.

Decomposition:
- Package rr_arb_mux_pkg holds:
  - the index-wrap helper function next_idx(idx, n)
  - the default-parameter constants
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr; output one-hot gnt[N] and binary gnt_idx. It is purely combinational, and ptr remains in the parent.
- Top-level rr_arb_mux holds the output register, the ptr register, and data selection from gnt_idx.

Test Plan:
1. Reset and idle: N=4, W=4, rst_n=0 for 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, out_sel=0, in_ready=0. Release with in_valid=0 -> out_valid stays 0.
2. Rotation: in_valid=4'b1111, in_data=16'hDCBA, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles. out_data sequence A,B,C,D,A. No idle cycle.
3. Skip and wrap: ptr=3 after granting 2; in_valid=4'b0011 -> grant 0 next, then 1. in_valid=4'b0100 alone is granted immediately regardless of ptr.
4. Backpressure: out_valid=1 with out_sel=1, out_data=4'h5, out_ready=0 for 3 cycles while in_valid=4'b1111 -> in_ready=0, outputs stable, ptr unchanged. Raise out_ready -> the held beat drains and the next grant (2) loads in the same cycle.
5. Non-power-of-two: N_SLAVES=3, all valid -> out_sel 0,1,2,0. Index 3 never appears.
6. Mid-stream reset: assert rst_n=0 while out_valid=1 -> the next cycle has out_valid=0 and ptr=0. After release, the first grant is the lowest valid index. With RR_ARB_MUX_FORCE_SEL_EN: force_en=1, force_sel=2 -> only channel 2 is served, and ptr is unchanged afterwards.
